// File: rtl/multi_collision_scanner_pkg.sv
// Shared types for the multi-object collision scanner: FSM states and the
// box description used by position generators and the scanner.
package collision_pkg;

  localparam int DEF_COORD_W = 10;

  typedef enum logic [1:0] {IDLE, SCAN, DONE} state_e;

  typedef struct packed {
    logic [DEF_COORD_W-1:0] x;
    logic [DEF_COORD_W-1:0] y;
    logic [DEF_COORD_W-1:0] w;
    logic [DEF_COORD_W-1:0] h;
  } box_t;

endpackage

// File: rtl/multi_collision_scanner_aabb_overlap.sv
// Combinational axis-aligned box overlap test for one car/object pair.
// Sums are one bit wider than the coordinates so boxes near the edge never wrap.
module aabb_overlap #(
  parameter int W = 10
) (
  input  logic [W-1:0] ax_i,
  input  logic [W-1:0] ay_i,
  input  logic [W-1:0] aw_i,
  input  logic [W-1:0] ah_i,
  input  logic [W-1:0] bx_i,
  input  logic [W-1:0] by_i,
  input  logic [W-1:0] bw_i,
  input  logic [W-1:0] bh_i,
  input  logic         en_i,
  output logic         hit_o
);

  logic [W:0] a_r, a_b, b_r, b_b;
  logic       nonzero;

  assign a_r = {1'b0, ax_i} + {1'b0, aw_i};
  assign a_b = {1'b0, ay_i} + {1'b0, ah_i};
  assign b_r = {1'b0, bx_i} + {1'b0, bw_i};
  assign b_b = {1'b0, by_i} + {1'b0, bh_i};

  // A degenerate box can still straddle the other's edge under strict compares.
  assign nonzero = (aw_i != '0) && (ah_i != '0) && (bw_i != '0) && (bh_i != '0);

  assign hit_o = en_i && nonzero &&
                 ({1'b0, ax_i} < b_r) && (a_r > {1'b0, bx_i}) &&
                 ({1'b0, ay_i} < b_b) && (a_b > {1'b0, by_i});

endmodule

// File: rtl/multi_collision_scanner.sv
// Scans the player box against NUM_OBJ object boxes, one per clock, through a
// single shared comparator; reports hit mask, lowest hit and a confirmed crash.
module multi_collision_scanner
  import collision_pkg::*;
#(
  parameter int COORD_W = DEF_COORD_W,
  parameter int NUM_OBJ = 4,
  parameter int IDX_W   = (NUM_OBJ > 1) ? $clog2(NUM_OBJ) : 1,
  parameter int CONFIRM = 2
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       start,
  input  logic [COORD_W-1:0]         car_x,
  input  logic [COORD_W-1:0]         car_y,
  input  logic [COORD_W-1:0]         car_w,
  input  logic [COORD_W-1:0]         car_h,
  input  logic [NUM_OBJ*COORD_W-1:0] obj_x,
  input  logic [NUM_OBJ*COORD_W-1:0] obj_y,
  input  logic [NUM_OBJ*COORD_W-1:0] obj_w,
  input  logic [NUM_OBJ*COORD_W-1:0] obj_h,
  input  logic [NUM_OBJ-1:0]         obj_valid,
  input  logic                       crash_clr,
  output logic                       busy,
  output logic                       done,
  output logic [NUM_OBJ-1:0]         hit_mask,
  output logic                       any_hit,
  output logic [IDX_W-1:0]           first_hit_idx,
  output logic                       crash
);

  localparam int CNT_W = (CONFIRM > 0) ? $clog2(CONFIRM + 1) : 1;

  state_e                          state_q, state_d;
  logic [IDX_W-1:0]                idx_q, idx_d;
  logic [NUM_OBJ-1:0]              wmask_q, wmask_d;
  logic [COORD_W-1:0]              cx_q, cy_q, cw_q, ch_q;
  logic [NUM_OBJ-1:0][COORD_W-1:0] ox_q, oy_q, ow_q, oh_q;
  logic [NUM_OBJ-1:0]              ovld_q;
  logic [NUM_OBJ-1:0]              hit_mask_q;
  logic                            any_q, done_q, crash_q, crash_d;
  logic [IDX_W-1:0]                first_q;
  logic [CNT_W-1:0]                cnt_q, cnt_d, cnt_inc;
  logic                            obj_hit, frame_hit, reach;

  function automatic logic [IDX_W-1:0] lowest_set(input logic [NUM_OBJ-1:0] m);
    logic [IDX_W-1:0] f;
    f = '0;
    for (int i = NUM_OBJ - 1; i >= 0; i--)
      if (m[i]) f = IDX_W'(i);
    return f;
  endfunction

  aabb_overlap #(.W(COORD_W)) u_cmp (
    .ax_i (cx_q),
    .ay_i (cy_q),
    .aw_i (cw_q),
    .ah_i (ch_q),
    .bx_i (ox_q[idx_q]),
    .by_i (oy_q[idx_q]),
    .bw_i (ow_q[idx_q]),
    .bh_i (oh_q[idx_q]),
    .en_i (ovld_q[idx_q]),
    .hit_o(obj_hit)
  );

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    wmask_d = wmask_q;
    unique case (state_q)
      IDLE: if (start) begin
        state_d = SCAN;
        idx_d   = '0;
        wmask_d = '0;
      end
      SCAN: begin
        wmask_d[idx_q] = obj_hit;
        if (idx_q == IDX_W'(NUM_OBJ - 1)) state_d = DONE;
        else                              idx_d   = idx_q + 1'b1;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // A clear arriving with a confirming DONE loses to the set; the counter
  // then restarts from this frame alone.
  assign frame_hit = |wmask_q;
  assign cnt_inc   = (cnt_q == CNT_W'(CONFIRM)) ? cnt_q : cnt_q + 1'b1;
  assign reach     = frame_hit && (cnt_inc == CNT_W'(CONFIRM));

  always_comb begin
    cnt_d   = cnt_q;
    crash_d = crash_q;
    if (state_q == DONE) begin
      cnt_d   = !frame_hit ? '0 : (crash_clr ? CNT_W'(1) : cnt_inc);
      crash_d = (crash_q && !crash_clr) || reach;
    end else if (crash_clr) begin
      cnt_d   = '0;
      crash_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      idx_q      <= '0;
      wmask_q    <= '0;
      hit_mask_q <= '0;
      any_q      <= 1'b0;
      first_q    <= '0;
      done_q     <= 1'b0;
      crash_q    <= 1'b0;
      cnt_q      <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      wmask_q <= wmask_d;
      done_q  <= (state_q == DONE);
      crash_q <= crash_d;
      cnt_q   <= cnt_d;
      if (state_q == DONE) begin
        hit_mask_q <= wmask_q;
        any_q      <= frame_hit;
        first_q    <= lowest_set(wmask_q);
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      {cx_q, cy_q, cw_q, ch_q} <= '0;
      ox_q   <= '0;
      oy_q   <= '0;
      ow_q   <= '0;
      oh_q   <= '0;
      ovld_q <= '0;
    end else if (state_q == IDLE && start) begin
      {cx_q, cy_q, cw_q, ch_q} <= {car_x, car_y, car_w, car_h};
      ox_q   <= obj_x;
      oy_q   <= obj_y;
      ow_q   <= obj_w;
      oh_q   <= obj_h;
      ovld_q <= obj_valid;
    end
  end

  assign busy          = (state_q != IDLE);
  assign done          = done_q;
  assign hit_mask      = hit_mask_q;
  assign any_hit       = any_q;
  assign first_hit_idx = first_q;
  assign crash         = crash_q;

endmodule

// File: tb/tb_multi_collision_scanner.sv
// Scoreboard bench: frames push expected results; a negedge monitor pops and
// compares on every done pulse.
module tb_multi_collision_scanner;

  localparam int CW = 10;
  localparam int N  = 4;

  logic            clk, reset, start, crash_clr;
  logic [CW-1:0]   car_x, car_y, car_w, car_h;
  logic [N*CW-1:0] obj_x, obj_y, obj_w, obj_h;
  logic [N-1:0]    obj_valid;
  logic            busy, done, any_hit, crash;
  logic [N-1:0]    hit_mask;
  logic [1:0]      first_hit_idx;

  typedef struct {
    logic [N-1:0] m;
    logic [1:0]   f;
    logic         a;
    logic         c;
  } exp_t;

  exp_t sb[$];
  int   n_vec  = 0;
  int   n_miss = 0;

  multi_collision_scanner #(.COORD_W(CW), .NUM_OBJ(N), .IDX_W(2), .CONFIRM(2)) dut (
    .clk(clk), .reset(reset), .start(start),
    .car_x(car_x), .car_y(car_y), .car_w(car_w), .car_h(car_h),
    .obj_x(obj_x), .obj_y(obj_y), .obj_w(obj_w), .obj_h(obj_h),
    .obj_valid(obj_valid), .crash_clr(crash_clr),
    .busy(busy), .done(done), .hit_mask(hit_mask), .any_hit(any_hit),
    .first_hit_idx(first_hit_idx), .crash(crash)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

  always @(negedge clk) begin
    if (!reset && done) begin
      n_vec++;
      if (sb.size() == 0) begin
        n_miss++;
        $display("FAIL spurious_done: got mask=%b crash=%b, required no done", hit_mask, crash);
      end else begin
        exp_t e;
        e = sb.pop_front();
        if (hit_mask !== e.m || first_hit_idx !== e.f || any_hit !== e.a || crash !== e.c) begin
          n_miss++;
          $display("FAIL frame_result: got mask=%b first=%0d any=%b crash=%b, required mask=%b first=%0d any=%b crash=%b",
                   hit_mask, first_hit_idx, any_hit, crash, e.m, e.f, e.a, e.c);
        end
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_vec++;
    if (act !== req) begin
      n_miss++;
      $display("FAIL %s: got %0d, required %0d", name, act, req);
    end
  endtask

  task automatic set_obj(input int i, input int x, input int y, input int w, input int h);
    obj_x[i*CW +: CW] = CW'(x);
    obj_y[i*CW +: CW] = CW'(y);
    obj_w[i*CW +: CW] = CW'(w);
    obj_h[i*CW +: CW] = CW'(h);
  endtask

  task automatic cfg_far();
    car_x = 100; car_y = 400; car_w = 32; car_h = 48;
    for (int i = 0; i < N; i++) set_obj(i, 300, 50, 32, 48);
    obj_valid = 4'b1111;
  endtask

  // Object 0 overlaps but is masked off; object 2 overlaps and counts.
  task automatic cfg_hit();
    cfg_far();
    set_obj(0, 100, 400, 32, 48);
    set_obj(2, 110, 420, 32, 48);
    obj_valid = 4'b1110;
  endtask

  // snap: move inputs after the start edge and retrigger start mid-scan.
  task automatic run_frame(input logic [N-1:0] m, input logic [1:0] f, input logic a,
                           input logic c, input bit clr_at_done, input bit snap);
    int  k;
    bit  got;
    exp_t e;
    e.m = m; e.f = f; e.a = a; e.c = c;
    sb.push_back(e);
    @(negedge clk) start = 1'b1;
    @(posedge clk);
    @(negedge clk) start = 1'b0;
    k = 0; got = 0;
    while (!got && k < 20) begin
      @(posedge clk);
      k++;
      @(negedge clk);
      if (done) got = 1;
      if (snap && k == 1) cfg_far();
      if (snap && k == 2) begin
        chk("busy_mid_scan", 32'(busy), 1);
        start = 1'b1;
      end
      if (k == 3) start = 1'b0;
      if (clr_at_done && k == 4) crash_clr = 1'b1;
      if (k == 5) crash_clr = 1'b0;
    end
    chk("done_latency", k, 5);
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; crash_clr = 1'b0;
    obj_x = '0; obj_y = '0; obj_w = '0; obj_h = '0;
    cfg_far();
    repeat (3) @(negedge clk);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_done", 32'(done), 0);
    chk("rst_mask", 32'(hit_mask), 0);
    chk("rst_crash", 32'(crash), 0);
    reset = 1'b0;
    @(negedge clk);

    cfg_far(); run_frame(4'b0000, 0, 0, 0, 0, 0);
    chk("idle_after_done", 32'(busy), 0);
    cfg_hit(); run_frame(4'b0100, 2, 1, 0, 0, 0);
    cfg_hit(); run_frame(4'b0100, 2, 1, 1, 0, 0);

    @(negedge clk) crash_clr = 1'b1;
    @(negedge clk) crash_clr = 1'b0;
    chk("crash_clr", 32'(crash), 0);
    chk("clr_keeps_mask", 32'(hit_mask), 32'b0100);

    cfg_far(); set_obj(0, 132, 400, 32, 48);
    run_frame(4'b0000, 0, 0, 0, 0, 0);
    cfg_far(); car_x = 1020; set_obj(1, 1000, 400, 40, 48);
    run_frame(4'b0010, 1, 1, 0, 0, 0);

    cfg_far(); run_frame(4'b0000, 0, 0, 0, 0, 0);
    cfg_hit(); run_frame(4'b0100, 2, 1, 0, 0, 0);

    cfg_far(); set_obj(3, 100, 400, 0, 48); set_obj(1, 100, 400, 32, 0);
    run_frame(4'b0000, 0, 0, 0, 0, 0);

    cfg_hit(); run_frame(4'b0100, 2, 1, 0, 0, 0);
    cfg_hit(); run_frame(4'b0100, 2, 1, 1, 1, 0);

    cfg_hit(); run_frame(4'b0100, 2, 1, 1, 0, 1);
    repeat (10) @(negedge clk);

    cfg_hit();
    chk("crash_before_reset", 32'(crash), 1);
    @(negedge clk) start = 1'b1;
    @(negedge clk) start = 1'b0;
    @(negedge clk) reset = 1'b1;
    #1;
    chk("mid_rst_busy", 32'(busy), 0);
    chk("mid_rst_crash", 32'(crash), 0);
    chk("mid_rst_mask", 32'(hit_mask), 0);
    chk("mid_rst_any", 32'(any_hit), 0);
    chk("mid_rst_done", 32'(done), 0);
    repeat (2) @(negedge clk);
    reset = 1'b0;
    repeat (10) @(negedge clk);

    cfg_hit(); run_frame(4'b0100, 2, 1, 0, 0, 0);
    repeat (3) @(negedge clk);
    chk("scoreboard_drained", 32'(sb.size()), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule

// File: doc/multi_collision_scanner.md
Name: multi_collision_scanner

Overview:
- Checks the player car bounding box against NUM_OBJ traffic/obstacle boxes once per frame, one object per clock, through a single shared comparator.
- Reports a per-object hit mask, the lowest-index hit and an any-hit flag.
- Maintains a sticky crash flag, confirmed over CONFIRM consecutive frames, for the game-state controller.
- Sits between the object position generators and the game FSM / VGA overlay.

Parameters:
- COORD_W, 10, width of every x/y/width/height field.
- NUM_OBJ, 4, number of traffic objects scanned per frame (>=1).
- IDX_W, $clog2(NUM_OBJ) (min 1), width of object index.
- CONFIRM, 2, consecutive hit frames required to set crash (>=1).

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-high reset.
- start  in  1  frame pulse; begins a scan when idle.
- car_x, car_y, car_w, car_h  in  COORD_W each  player box (top-left and size).
- obj_x, obj_y, obj_w, obj_h  in  NUM_OBJ*COORD_W each  packed object boxes; object i at bits [i*COORD_W +: COORD_W].
- obj_valid  in  NUM_OBJ  object i participates when 1.
- crash_clr  in  1  clears sticky crash and the confirm counter.
- busy  out  1  scan in progress.
- done  out  1  one-cycle pulse when results update.
- hit_mask  out  NUM_OBJ  per-object overlap result of the last completed scan.
- any_hit  out  1  OR of hit_mask.
- first_hit_idx  out  IDX_W  lowest i with hit_mask[i]=1; 0 if none.
- crash  out  1  sticky confirmed-collision flag.

Behaviour:
- Reset (async, active-high): all outputs 0, FSM to IDLE, confirm counter 0, snapshot registers 0.
- FSM states:
  - IDLE: start=1 -> SCAN. On that edge, snapshot all car_* / obj_* / obj_valid inputs and set index=0.
  - SCAN: evaluate object[index] from the snapshot and write the result into a working mask. index==NUM_OBJ-1 -> DONE, else index+1.
  - DONE: copy the working mask to hit_mask, update any_hit, first_hit_idx and crash logic, pulse done=1 -> IDLE.
- Latency: start sampled at edge 0. busy=1 for edges 1..NUM_OBJ+1. done high for exactly one cycle, NUM_OBJ+1 cycles after start. Outputs change only at the DONE transition and hold otherwise.
- start while busy is ignored: no queueing, no restart. Inputs changing after the start edge do not affect the scan.
- Overlap rule for object i, with all sums computed at COORD_W+1 bits so there is no wrap:
  - car_x < ox+ow AND car_x+car_w > ox AND car_y < oy+oh AND car_y+car_h > oy AND obj_valid[i].
  - Edge-touching boxes are not hits. Any zero width or height gives no hit.
- Confirm counter (width $clog2(CONFIRM+1)):
  - At DONE, any_hit=1 -> counter saturating +1; any_hit=0 -> counter=0.
  - crash sets when the counter reaches CONFIRM and stays set until crash_clr or reset.
- crash_clr clears crash and the counter at the next edge in any state.
- crash_clr coincident with a DONE that would reach CONFIRM: set wins, crash=1, and the counter restarts at 1 when the frame hit. crash_clr does not affect hit_mask.
- Mid-scan reset aborts the scan and clears everything; a scan interrupted by reset produces no done.

Decomposition:
- Package collision_pkg: COORD_W default, state enum typedef {IDLE, SCAN, DONE}, and a box struct typedef {x,y,w,h}.
- One natural sub-module: aabb_overlap, a combinational single-pair overlap test with the widened-sum rule above, instantiated once and shared across the scan.

Test Plan:
- No overlap (defaults):
  - Stimulus: car (100,400,32,48) vs objects at (300,50,32,48)x4, all valid, start pulse.
  - Response: done exactly 5 cycles after start, hit_mask=0000, any_hit=0, crash=0.
- Single hit, invalid masking:
  - Stimulus: object 2 at (110,420,32,48) valid, object 0 overlapping but obj_valid[0]=0.
  - Response: hit_mask=0100, first_hit_idx=2, any_hit=1.
- Edge touch and wrap:
  - Stimulus: object at (132,400,32,48) touching the car's right edge, then object at (1000,400,40,48) with car_x=1020 (sum exceeds 1023).
  - Response: first not a hit; second is a hit (no wrap).
- Confirm and clear, CONFIRM=2:
  - Stimulus: hit frame, then hit frame, then crash_clr; separately, hit / miss / hit frames.
  - Response: crash rises at the second done and falls the cycle after crash_clr; hit/miss/hit leaves crash=0.
- Busy and snapshot:
  - Stimulus: second start at scan cycle 2; inputs moved to non-overlapping positions at cycle 1.
  - Response: single done, results reflect the start-edge snapshot.
- Reset mid-operation:
  - Stimulus: async reset asserted during SCAN with crash=1.
  - Response: all outputs 0 immediately, no done pulse, next start scans normally.
